// File: rtl/trap_pulse_ctrl.sv
`default_nettype none
// trap_pulse_ctrl: trapezoidal-filter sequencer (flush, trigger, flat-top sample, handshake), rev 1.0.
// Optional trigger timestamp on out_ts when TRAP_PULSE_CTRL_TIMESTAMP_EN is defined.
module trap_pulse_ctrl #(
  parameter int DATA_W    = 16,
  parameter int FLUSH_LEN = 16,
  parameter int PEAK_DLY  = 12,
  parameter int HOLDOFF   = 8,
  parameter int TS_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] thresh,
  input  logic [DATA_W-1:0] filt_data,
  output logic              filt_clr,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_amp,
  output logic              out_pileup,
`ifdef TRAP_PULSE_CTRL_TIMESTAMP_EN
  output logic [TS_W-1:0]   out_ts,
`endif
  output logic [7:0]        pileup_cnt
);

  // One shared down-counter serves flush, peak delay and holdoff; PEAK_DLY/HOLDOFF fit in 8 bits.
  localparam int CNT_W = (FLUSH_LEN > 256) ? $clog2(FLUSH_LEN) : 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ARMED  = 3'd2,
    RISE   = 3'd3,
    REPORT = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             below;
  logic             pile;
  logic             above;

  assign above = $signed(filt_data) > $signed(thresh);

`ifdef TRAP_PULSE_CTRL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_trig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      below      <= 1'b0;
      pile       <= 1'b0;
      filt_clr   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_amp    <= '0;
      out_pileup <= 1'b0;
      pileup_cnt <= '0;
`ifdef TRAP_PULSE_CTRL_TIMESTAMP_EN
      ts_trig    <= '0;
      out_ts     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= CLEAR;
            cnt   <= CNT_W'(FLUSH_LEN - 1);
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state    <= ARMED;
            filt_clr <= 1'b0;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARMED: begin
          if (!enable) begin
            state    <= IDLE;
            filt_clr <= 1'b1;
          end else if (above) begin
            state <= RISE;
            cnt   <= CNT_W'(PEAK_DLY - 1);
            below <= 1'b0;
            pile  <= 1'b0;
            busy  <= 1'b1;
`ifdef TRAP_PULSE_CTRL_TIMESTAMP_EN
            ts_trig <= ts_cnt;
`endif
          end
        end
        RISE: begin
          if (!enable) begin
            state    <= IDLE;
            filt_clr <= 1'b1;
            busy     <= 1'b0;
          end else if (cnt == '0) begin
            // pile reflects the edges before the sample edge
            state      <= REPORT;
            out_valid  <= 1'b1;
            out_amp    <= filt_data;
            out_pileup <= pile;
`ifdef TRAP_PULSE_CTRL_TIMESTAMP_EN
            out_ts     <= ts_trig;
`endif
          end else begin
            cnt <= cnt - 1'b1;
            if (!above)     below <= 1'b1;
            else if (below) pile  <= 1'b1;
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_pileup && pileup_cnt != 8'hFF) pileup_cnt <= pileup_cnt + 1'b1;
            if (enable) begin
              state <= HOLD;
              cnt   <= CNT_W'(HOLDOFF);
            end else begin
              state    <= IDLE;
              filt_clr <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!enable) begin
            state    <= IDLE;
            filt_clr <= 1'b1;
            busy     <= 1'b0;
          end else if (cnt == '0) begin
            if (!above) begin
              state <= ARMED;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          filt_clr  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
